// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes, FSM states
// and operation-class helpers.
package mdu_iter_pkg;

  typedef enum logic [3:0] {
    MDU_NOP      = 4'd0,
    MDU_OP_MUL   = 4'd1,
    MDU_OP_MULW  = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_REM   = 4'd5,
    MDU_OP_REMU  = 4'd6,
    MDU_OP_DIVW  = 4'd7,
    MDU_OP_DIVUW = 4'd8,
    MDU_OP_REMW  = 4'd9,
    MDU_OP_REMUW = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_DONE
  } mdu_state_t;

  localparam int unsigned MDU_MUL_STEP_DEFAULT = 4;

  // Codes outside the table are treated like MDU_NOP and never accepted.
  function automatic logic op_supported(mdu_op_t op);
    return op inside {MDU_OP_MUL, MDU_OP_MULW, MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_REM,
                      MDU_OP_REMU, MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

  function automatic logic op_is_mul(mdu_op_t op);
    return op inside {MDU_OP_MUL, MDU_OP_MULW};
  endfunction

  function automatic logic op_is_word(mdu_op_t op);
    return op inside {MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

  function automatic logic op_is_signed(mdu_op_t op);
    return op inside {MDU_OP_DIV, MDU_OP_REM, MDU_OP_DIVW, MDU_OP_REMW};
  endfunction

  function automatic logic op_is_rem(mdu_op_t op);
    return op inside {MDU_OP_REM, MDU_OP_REMU, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Serial restoring unsigned divider: one quotient bit per cycle after start_i,
// done_o pulses for one cycle once all bits are produced.
module mdu_divider #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            word_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            word_q, word_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    word_d  = word_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[XLEN-1]};
    // A borrow out of the top bit means the divisor does not fit: restore.
    trial   = shifted - {1'b0, dsr_q};
    if (start_i) begin
      // Word ops park the 32-bit dividend in the top half so its MSB shifts out first.
      quo_d  = word_i ? (dividend_i << (XLEN - 32)) : dividend_i;
      rem_d  = '0;
      dsr_d  = divisor_i;
      cnt_d  = word_i ? CntW'(32) : CntW'(XLEN);
      busy_d = 1'b1;
      word_d = word_i;
    end else if (busy_q) begin
      rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      word_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    quotient_o = quo_q;
    if (word_q) begin
      quotient_o          = '0;
      quotient_o[31:0]    = quo_q[31:0];
    end
  end

  assign remainder_o = rem_q;
  assign done_o      = done_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiplier retiring MUL_STEP bits per
// cycle, serial restoring divider, valid/ready on both sides and a flush.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MUL_STEP = MDU_MUL_STEP_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      in_op_i,
  input  logic [XLEN-1:0] in_a_i,
  input  logic [XLEN-1:0] in_b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o
);

  localparam int unsigned CntW        = $clog2(XLEN / MUL_STEP + 1);
  localparam logic [CntW-1:0] MulCycles  = CntW'(XLEN / MUL_STEP);
  localparam logic [CntW-1:0] MulCyclesW = CntW'(32 / MUL_STEP);

  function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = v[31] ? '1 : '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_first_q, div_first_d;

  mdu_op_t         op_in;
  logic            in_w, in_s, in_rem;
  logic [XLEN-1:0] a_prep, b_prep, min_val;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] early_quo, early_rem;

  logic            op_w, op_s;
  logic [XLEN-1:0] pp;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem;
  logic [XLEN-1:0] fix_quo, fix_rem, fix_raw;

  // Operand preparation and divide special cases, evaluated on the offered op.
  always_comb begin
    op_in   = mdu_op_t'(in_op_i);
    in_w    = op_is_word(op_in);
    in_s    = op_is_signed(op_in);
    in_rem  = op_is_rem(op_in);
    a_prep  = in_a_i;
    b_prep  = in_b_i;
    if (in_w) begin
      a_prep = in_s ? sext32(in_a_i[31:0]) : zext32(in_a_i[31:0]);
      b_prep = in_s ? sext32(in_b_i[31:0]) : zext32(in_b_i[31:0]);
    end
    min_val           = '0;
    min_val[XLEN-1]   = 1'b1;
    if (in_w) min_val = sext32(32'h8000_0000);
    div_zero  = (b_prep == '0);
    div_ovf   = in_s && (a_prep == min_val) && (b_prep == '1);
    early_quo = div_zero ? '1 : a_prep;
    early_rem = div_zero ? (in_w ? sext32(in_a_i[31:0]) : in_a_i) : '0;
  end

  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (b_q[i]) pp = pp + (a_q << i);
    end
  end

  always_comb begin
    op_w    = op_is_word(op_q);
    op_s    = op_is_signed(op_q);
    a_abs   = (op_s && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs   = (op_s && b_q[XLEN-1]) ? -b_q : b_q;
    fix_quo = (op_s && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quo : div_quo;
    fix_rem = (op_s && a_q[XLEN-1]) ? -div_rem : div_rem;
    fix_raw = op_is_rem(op_q) ? fix_rem : fix_quo;
  end

  mdu_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_i    (div_start),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .word_i     (op_w),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    div_first_d = div_first_q;
    div_start   = 1'b0;
    if (flush_i) begin
      state_d     = MDU_IDLE;
      div_first_d = 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (in_valid_i && op_supported(op_in)) begin
            op_d  = op_in;
            a_d   = a_prep;
            b_d   = b_prep;
            acc_d = '0;
            if (op_is_mul(op_in)) begin
              state_d = MDU_MUL;
              cnt_d   = in_w ? MulCyclesW : MulCycles;
            end else if (div_zero || div_ovf) begin
              state_d  = MDU_DONE;
              result_d = in_rem ? early_rem : early_quo;
            end else begin
              state_d     = MDU_DIV;
              div_first_d = 1'b1;
            end
          end
        end
        MDU_MUL: begin
          if (cnt_q != '0) begin
            acc_d = acc_q + pp;
            a_d   = a_q << MUL_STEP;
            b_d   = b_q >> MUL_STEP;
            cnt_d = cnt_q - CntW'(1);
          end else begin
            result_d = op_w ? sext32(acc_q[31:0]) : acc_q;
            state_d  = MDU_DONE;
          end
        end
        MDU_DIV: begin
          // First cycle hands absolute values to the core; the cycle after its
          // done pulse applies the signs.
          if (div_first_q) begin
            div_start   = 1'b1;
            div_first_d = 1'b0;
          end else if (div_done) begin
            result_d = op_w ? sext32(fix_raw[31:0]) : fix_raw;
            state_d  = MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (out_ready_i) state_d = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= MDU_IDLE;
      op_q        <= MDU_NOP;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      div_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      div_first_q <= div_first_d;
    end
  end

  assign in_ready_o   = (state_q == MDU_IDLE);
  assign out_valid_o  = (state_q == MDU_DONE);
  assign out_result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=64, MUL_STEP=4): results, latencies,
// early-out, backpressure, flush and asynchronous reset.
module tb_mdu_iter;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MUL   = 4'd1;
  localparam logic [3:0] OP_MULW  = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_REM   = 4'd5;
  localparam logic [3:0] OP_REMU  = 4'd6;
  localparam logic [3:0] OP_DIVW  = 4'd7;
  localparam logic [3:0] OP_REMW  = 4'd9;
  localparam logic [3:0] OP_REMUW = 4'd10;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;
  int edges;
  logic seen;

  mdu_iter #(
    .XLEN    (64),
    .MUL_STEP(4)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_result_o(out_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op for a single edge, then scramble the inputs to prove capture.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_op    = 4'($urandom_range(0, 15));
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    issue(op, a, b);
    wait_valid(edges);
    check({tag, "_lat"}, 64'(edges), 64'(lat));
    check({tag, "_res"}, out_result, exp);
    take();
    check({tag, "_idle"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_NOP;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", out_result, 64'd0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", 64'(in_ready), 64'd1);

    run("mul", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 17);
    run("mulw_neg", OP_MULW, 64'hABCD_0000_4000_0000, 64'd3, 64'hFFFF_FFFF_C000_0000, 9);
    run("div", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run("rem", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run("remuw", OP_REMUW, 64'h1_0000_0007, 64'd2, 64'd1, 34);
    run("divw", OP_DIVW, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34);
    run("divu_z", OP_DIVU, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_z", OP_REMU, 64'd100, 64'd0, 64'd100, 1);
    run("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    // Backpressure: result held while out_ready stays low.
    issue(OP_MULW, 64'd3, 64'd5);
    wait_valid(edges);
    check("bp_lat", 64'(edges), 64'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_result", out_result, 64'd15);
      check("bp_flags", {62'd0, out_valid, in_ready}, 64'b10);
    end
    in_op     = OP_MUL;
    in_a      = 64'd6;
    in_b      = 64'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check("bp_handoff", {62'd0, out_valid, in_ready}, 64'b01);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("bp_accept", 64'(in_ready), 64'd0);
    wait_valid(edges);
    check("bp_next_lat", 64'(edges), 64'd17);
    check("bp_next_res", out_result, 64'd42);
    take();

    // Flush in the 10th DIV cycle.
    issue(OP_DIV, 64'd1000, 64'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_div", {62'd0, out_valid, in_ready}, 64'b01);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Flush alongside an offered op: dropped.
    in_op    = OP_DIVU;
    in_a     = 64'd1;
    in_b     = 64'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    check("flush_idle", {62'd0, out_valid, in_ready}, 64'b01);

    // NOP is never accepted.
    in_op    = OP_NOP;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("nop", {62'd0, out_valid, in_ready}, 64'b01);

    // Flush in DONE discards the result even with out_ready high.
    issue(OP_DIVU, 64'd7, 64'd0);
    check("fd_valid", 64'(out_valid), 64'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    check("fd_idle", {62'd0, out_valid, in_ready}, 64'b01);

    // Asynchronous reset mid-multiply.
    issue(OP_MUL, 64'd123, 64'd456);
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_result", out_result, 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    #3;
    reset_n = 1'b1;
    tick();
    run("post_rst", OP_MUL, 64'd6, 64'd7, 64'd42, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit executing every non-NOP `mdu_op_t` operation.
- Generalises the single-cycle MDU: width-parametrised; multiplier retires MUL_STEP bits per cycle; divider is a 1-bit/cycle restoring divider.
- Adds valid/ready handshakes on both sides, a pipeline flush, and 1-cycle early-out for divide special cases.
- Sits in the execute stage. Execute stalls while `in_ready` or `out_valid` withholds progress.

Parameters:
- XLEN, 64, datapath width; operands and result are XLEN bits.
- MUL_STEP, 4, multiplier bits retired per cycle; must be one of 1, 2, 4, 8, 16, 32.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; high only in IDLE
- in_op  in  4  mdu_op_t
- in_a  in  XLEN  operand rs1
- in_b  in  XLEN  operand rs2
- flush  in  1  synchronous kill of in-flight or offered op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result

Behaviour:
- Reset (reset_n=0, asynchronous, honoured at any time including mid-operation):
  - state=IDLE; all counters and registers cleared.
  - in_ready=1 once reset deasserts; out_valid=0; out_result=0.
- States:
  - IDLE: accept when in_valid & in_ready & !flush & in_op!=MDU_NOP. MDU_NOP is never accepted and has no effect.
  - MUL: shift-add multiply. Retires MUL_STEP multiplier bits per cycle. Runs K=w/MUL_STEP cycles, where w=XLEN for MUL and w=32 for MULW. Then goes to DONE.
  - DIV: restoring division. The first cycle after accept takes absolute values for signed ops and loads counters. The following w cycles each produce 1 quotient bit (w=XLEN, or 32 for W ops). A final sign-fix cycle then goes to DONE. K=w+1 in total.
  - DONE: out_valid=1 and out_result held stable. On out_ready go to IDLE; otherwise stay.
- Latency: out_valid rises exactly K+1 edges after the accepting edge.
  - XLEN=64, MUL_STEP=4: MUL=16, MULW=8, DIV*=65, DIV*W=33.
- Arithmetic:
  - MUL returns the low XLEN bits of the product. Signedness is irrelevant for the low half.
  - W ops use in_a[31:0] and in_b[31:0]. The 32-bit result is sign-extended to XLEN, including DIVUW/REMUW.
  - Signed quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Early-out: the IDLE accept edge goes directly to DONE, giving out_valid 1 edge after accept.
  - Divide by zero: quotient = all ones; remainder = dividend (after W truncation and sign-extension).
  - Signed overflow (min_int / -1): quotient = dividend; remainder = 0.
- Flush: has priority over every other event.
  - State goes to IDLE on the next edge; out_valid=0 next cycle; no result is produced.
  - flush together with in_valid in IDLE: the op is dropped.
  - flush in DONE: the result is discarded even when out_ready is high.
- Backpressure: in DONE with out_ready=0, out_result and out_valid remain constant; in_ready=0.
- No accept in DONE. A new op is accepted earliest in the cycle after the handoff (one bubble).
- Operands are captured at accept. in_a, in_b and in_op are don't-care afterwards.

Decomposition:
- Package pipes gains:
  - `mdu_state_t` enum {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE}.
  - Constant MDU_MUL_STEP_DEFAULT=4.
- `mdu_op_t` is reused unchanged.
- Sub-module `mdu_divider`: serial restoring unsigned core.
  - Inputs: start, dividend, divisor, width-select.
  - Outputs: quotient, remainder, done.
- Sign handling, early-out, multiplier and FSM stay in `mdu_iter`.

Test Plan:
- MUL a=7, b=0xFFFFFFFFFFFFFFFD -> out_result 0xFFFFFFFFFFFFFFEB; out_valid 17 edges after accept.
- DIV a=-7, b=2 -> 0xFFFFFFFFFFFFFFFD after 66 edges; REM same operands -> 0xFFFFFFFFFFFFFFFF; REMUW a=0x1_00000007, b=2 -> 1.
- DIVU a=100, b=0 -> 0xFFFFFFFFFFFFFFFF; REMU -> 100; DIVW a=0x80000000, b=-1 -> 0xFFFFFFFF80000000; REMW -> 0; each out_valid 1 edge after accept.
- Backpressure: MULW 3*5, out_ready low 5 cycles -> out_result=15 held, in_ready=0 throughout; out_ready=1 -> IDLE next edge; next op accepted the cycle after.
- Flush on 10th DIV cycle -> IDLE next edge, in_ready=1, out_valid never rises. flush with in_valid in IDLE -> nothing accepted. MDU_NOP with in_valid -> ignored.
- reset_n low mid-MUL (asynchronous, between edges) -> out_valid=0, out_result=0 immediately; after release a fresh MUL 6*7 returns 42.
